// File: rtl/demux_reg8_32bit.sv
// Write-side register bank feeding the 8:1 operand mux: one handshaked write per cycle into
// one of eight registers, plus a sequenced one-register-per-cycle bank clear.
module demux_reg8_32bit #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done,
    output logic [7:0]       wr_count,
    output logic [WIDTH-1:0] O0,
    output logic [WIDTH-1:0] O1,
    output logic [WIDTH-1:0] O2,
    output logic [WIDTH-1:0] O3,
    output logic [WIDTH-1:0] O4,
    output logic [WIDTH-1:0] O5,
    output logic [WIDTH-1:0] O6,
    output logic [WIDTH-1:0] O7
);

    localparam int unsigned NUM_REGS = 8;
    localparam int unsigned IDX_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] bank [NUM_REGS];
    logic             wr_fire;

    // Clear request has priority over a simultaneous write, so it gates ready.
    assign wr_ready = (state == IDLE) && !clr_req;
    assign wr_fire  = wr_valid && wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            wr_count <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= CLR_VAL;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state    <= CLEAR;
                        idx      <= '0;
                        clr_busy <= 1'b1;
                    end else if (wr_fire) begin
                        bank[wr_sel] <= wr_data;
                        wr_count     <= wr_count + 8'd1;
                    end
                end
                CLEAR: begin
                    bank[idx] <= CLR_VAL;
                    idx       <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_REGS - 1)) begin
                        state    <= DONE;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

    assign O0 = bank[0];
    assign O1 = bank[1];
    assign O2 = bank[2];
    assign O3 = bank[3];
    assign O4 = bank[4];
    assign O5 = bank[5];
    assign O6 = bank[6];
    assign O7 = bank[7];

endmodule
